// File: rtl/fifo_strobe_buff.sv
// Single-clock byte-stream FIFO whose pointers advance when bus strobes fall.
// Optional flush input and logic are compiled in when FIFO_FLUSH_EN is defined.
module fifo_strobe_buff #(
  parameter int DW        = 8,
  parameter int AW        = 11,
  parameter int AF_MARGIN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] di,
  input  logic          we,
  input  logic          oe,
  input  logic          err_clr,
  output logic [DW-1:0] dato,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf
`ifdef FIFO_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] dato_q;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   lvl_after, free_w;
  logic [1:0]    we_st_q, we_st_d, oe_st_q, oe_st_d;
  logic          write_ok_q, write_ok_d;
  logic          oe_prev_q;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          we_end, oe_end, we_first, full_after, wr_en;

  assign level       = wr_ptr_q - rd_ptr_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign free_w      = DEPTH_V - level;
  assign almost_full = (int'(free_w) <= AF_MARGIN);
  assign dato        = dato_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;

  always_comb begin
    we_end     = (we_st_q == 2'b10);
    oe_end     = (oe_st_q == 2'b10);
    we_first   = we & ~we_st_q[0];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (we_end && write_ok_q) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (oe_end)               rd_ptr_d = rd_ptr_q + PTR_ONE;
    // A strobe starting on the edge where the previous one commits must see
    // the post-commit fill, and must write into the post-commit slot.
    lvl_after  = wr_ptr_d - rd_ptr_q;
    full_after = lvl_after[AW];
    write_ok_d = we_first ? ~full_after : write_ok_q;
    wr_en      = we & write_ok_d;
    we_st_d    = {we_st_q[0], we};
    oe_st_d    = {oe_st_q[0], oe & ~empty};
    ovf_d      = (ovf_q & ~err_clr) | (we_end & ~write_ok_q);
    udf_d      = (udf_q & ~err_clr) | (oe & ~oe_prev_q & empty);
`ifdef FIFO_FLUSH_EN
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      oe_st_d  = 2'b00;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      we_st_q    <= 2'b00;
      oe_st_q    <= 2'b00;
      write_ok_q <= 1'b0;
      oe_prev_q  <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      dato_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      we_st_q    <= we_st_d;
      oe_st_q    <= oe_st_d;
      write_ok_q <= write_ok_d;
      oe_prev_q  <= oe;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      dato_q     <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_d[AW-1:0]] <= di;
  end

endmodule

// File: tb/tb_fifo_strobe_buff.sv
// Directed bench for fifo_strobe_buff at AW=4, AF_MARGIN=2.
// Flush scenarios run only when built with FIFO_FLUSH_EN.
module tb_fifo_strobe_buff;

  logic       clk = 1'b0;
  logic       rst, we, oe, err_clr, flush;
  logic [7:0] di, dato;
  logic       empty, full, almost_full, ovf, udf;
  logic [4:0] level;

  int errs   = 0;
  int checks = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  fifo_strobe_buff #(.DW(8), .AW(4), .AF_MARGIN(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .di          (di),
    .we          (we),
    .oe          (oe),
    .err_clr     (err_clr),
    .dato        (dato),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .ovf         (ovf),
    .udf         (udf)
`ifdef FIFO_FLUSH_EN
    ,
    .flush       (flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input int hold);
    di = d;
    we = 1'b1;
    repeat (hold) tick();
    we = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop();
    logic [7:0] e;
    e = q.pop_front();
    check("pop_data", 32'(dato), 32'(e));
    oe = 1'b1;
    tick();
    oe = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; oe = 1'b0; di = '0; err_clr = 1'b0; flush = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_udf", 32'(udf), 32'd0);
    check("rst_dato", 32'(dato), 32'd0);

    // single word, strobe held 4 cycles; commit lands two edges after the fall
    di = 8'hA5;
    we = 1'b1;
    repeat (4) tick();
    we = 1'b0;
    check("wr_lvl_held", 32'(level), 32'd0);
    tick();
    check("wr_lvl_k1", 32'(level), 32'd0);
    tick();
    check("wr_lvl_k2", 32'(level), 32'd1);
    check("wr_empty", 32'(empty), 32'd0);
    tick();
    check("wr_dato", 32'(dato), 32'hA5);
    oe = 1'b1;
    repeat (3) tick();
    oe = 1'b0;
    tick();
    check("rd_lvl_k1", 32'(level), 32'd1);
    tick();
    check("rd_lvl_k2", 32'(level), 32'd0);
    check("rd_empty", 32'(empty), 32'd1);
    check("rd_udf", 32'(udf), 32'd0);
    tick();

    // fill to full, overflow, then drain in order
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1);
      q.push_back(8'(i));
      check("fill_level", 32'(level), 32'(i + 1));
      if (i == 12) check("af_at13", 32'(almost_full), 32'd0);
      if (i == 13) check("af_at14", 32'(almost_full), 32'd1);
    end
    check("full_flag", 32'(full), 32'd1);
    check("full_af", 32'(almost_full), 32'd1);
    check("full_ovf_pre", 32'(ovf), 32'd0);
    push(8'hEE, 2);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_full", 32'(full), 32'd1);
    tick();
    while (q.size() > 0) pop();
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_ovf_sticky", 32'(ovf), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);

    // interleaved traffic across pointer wrap
    for (int i = 0; i < 40; i++) begin
      push(8'h40 + 8'(i), 1);
      q.push_back(8'h40 + 8'(i));
      check("wrap_level", 32'(level), 32'(q.size()));
      if (i % 3 == 2) begin
        tick();
        pop();
        pop();
        check("wrap_level_rd", 32'(level), 32'(q.size()));
      end
    end
    tick();
    while (q.size() > 0) pop();
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_ovf", 32'(ovf), 32'd0);
    check("wrap_udf", 32'(udf), 32'd0);

    // underflow and its clear
    oe = 1'b1;
    tick();
    oe = 1'b0;
    tick();
    check("udf_set", 32'(udf), 32'd1);
    check("udf_level", 32'(level), 32'd0);
    push(8'h91, 1);
    q.push_back(8'h91);
    tick();
    pop();
    check("udf_rd_ok", 32'(empty), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("udf_clr", 32'(udf), 32'd0);
    err_clr = 1'b1;
    oe = 1'b1;
    tick();
    err_clr = 1'b0;
    oe = 1'b0;
    tick();
    check("udf_set_wins", 32'(udf), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("udf_clr2", 32'(udf), 32'd0);

    // read and write completing together
    for (int i = 0; i < 5; i++) begin
      push(8'h60 + 8'(i), 1);
      q.push_back(8'h60 + 8'(i));
    end
    tick();
    check("sim_level_pre", 32'(level), 32'd5);
    check("sim_head", 32'(dato), 32'h60);
    di = 8'h65;
    we = 1'b1;
    oe = 1'b1;
    tick();
    tick();
    we = 1'b0;
    oe = 1'b0;
    tick();
    tick();
    void'(q.pop_front());
    q.push_back(8'h65);
    check("sim_level", 32'(level), 32'd5);
    tick();
    while (q.size() > 0) pop();
    check("sim_empty", 32'(empty), 32'd1);

`ifdef FIFO_FLUSH_EN
    for (int i = 0; i < 7; i++) push(8'h30 + 8'(i), 1);
    check("fl_level_pre", 32'(level), 32'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_empty", 32'(empty), 32'd1);
    check("fl_level", 32'(level), 32'd0);
    di = 8'h77;
    we = 1'b1;
    tick();
    we = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_we_level", 32'(level), 32'd1);
    tick();
    check("fl_we_dato", 32'(dato), 32'h77);
    q.push_back(8'h77);
    pop();
    check("fl_end_empty", 32'(empty), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fifo_strobe_buff.md
Name: fifo_strobe_buff

Overview:
- Parametrised single-clock FIFO for CPU and PI bus byte streams, the next generation of the fixed 2 KB x 8 mailbox buffer.
- Data width and depth are parameters. Adds full detection, fill level, and sticky overflow/underflow error flags.
- Pointers advance on completion (falling edge) of bus strobes, so multi-cycle bus accesses move exactly one word.
- Instantiated once per direction (ARM->CPU, CPU->ARM) inside the mailbox wrapper.

Parameters:
DW, 8, data width in bits
AW, 11, address width; depth = 2**AW words
AF_MARGIN, 16, almost-full threshold: almost_full asserted when free words <= AF_MARGIN

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
di  in  DW  write data
we  in  1  write strobe (level, may be held many cycles)
oe  in  1  read strobe (level, may be held many cycles)
err_clr  in  1  clears ovf/udf
dato  out  DW  data at read pointer (registered)
empty  out  1  no words stored
full  out  1  2**AW words stored
almost_full  out  1  free words <= AF_MARGIN
level  out  AW+1  words stored, 0..2**AW
ovf  out  1  sticky: write completed while full
udf  out  1  sticky: read started while empty
flush  in  1  present only with FIFO_FLUSH_EN

Behaviour:
- Reset (sync, rst=1 at a clk edge): wr_ptr=rd_ptr=0, strobe history=00, ovf=udf=0, dato=0. Outputs after reset: empty=1, full=0, level=0, almost_full=0 (when AF_MARGIN < 2**AW).
- Reset applied mid-strobe: the pending strobe is discarded and no pointer moves. A strobe still high after reset release counts as a new access and completes on its fall.
- Pointers are AW+1 bits. Derived flags:
  - empty = (wr_ptr == rd_ptr)
  - full = MSBs differ and low AW bits equal
  - level = wr_ptr - rd_ptr, modulo 2**(AW+1)
- Write path:
  - While we=1 and write_ok, RAM[wr_ptr[AW-1:0]] <= di every cycle, so the last value before we falls wins.
  - write_ok is latched on the first cycle we is sampled high: write_ok = !full.
  - we_st <= {we_st[0], we}. we_end = (we_st == 2'b10).
  - On we_end: if write_ok, wr_ptr += 1; else ovf <= 1 and RAM is untouched.
  - Latency: we sampled 1 at edge k and 0 at edge k+1 → wr_ptr, level and flags update at edge k+2.
- Read path:
  - oe_st <= {oe_st[0], oe & !empty}. oe_end = (oe_st == 2'b10); on oe_end, rd_ptr += 1.
  - oe sampled high while empty sets udf, once per strobe (rising edge of oe). rd_ptr does not move.
  - dato <= RAM[rd_ptr] every cycle (1-cycle read latency). After rd_ptr moves, dato is valid one edge later. dato reads stale data while empty.
- Simultaneous events:
  - we_end and oe_end on the same edge: both pointers move, level unchanged.
  - Write into an empty FIFO: empty deasserts at edge k+2; dato shows the new word at k+3.
- Wrap-around: low AW bits wrap from 2**AW-1 to 0; the MSB toggles.
- Error flags: ovf/udf hold until err_clr=1 at a clk edge. A set event in the same edge as err_clr wins (flag stays 1).
- Arithmetic: all pointer math is unsigned AW+1 bits with natural wrap. No saturation.

Optional Feature:
- Macro: FIFO_FLUSH_EN.
- Defined:
  - The flush port exists. flush=1 at an edge sets rd_ptr <= wr_ptr, clears oe_st, and leaves wr_ptr and RAM contents alone.
  - A write completing on the same edge is still committed, and rd_ptr takes the pre-increment wr_ptr. level then reads 1.
  - Priority: rst > flush > normal.
- Undefined: no flush port and no flush logic. Buffers are emptied only by reading out or by rst.

Test Plan:
- Reset then write 0xA5 with we held 4 cycles → level 0→1 exactly 2 edges after we falls; empty=0; dato=0xA5 one edge later; oe held 3 cycles → level=0, empty=1.
- AW=4: write 16 bytes 0x00..0x0F → full=1, level=16, almost_full=1 (AF_MARGIN=2 from level 14). 17th write → ovf=1, level stays 16. Read all 16 in order 0x00..0x0F.
- Wrap: AW=4, write/read 40 bytes interleaved → data order preserved, pointers wrap, level never exceeds 16, ovf=udf=0.
- oe pulse while empty → udf=1, rd_ptr unchanged. err_clr pulse → udf=0. err_clr coincident with a new empty read → udf stays 1.
- Simultaneous completion: level=5, we and oe fall on the same cycle → level stays 5, next dato is the correct next word.
- FIFO_FLUSH_EN: level=7, flush=1 → empty=1 next edge. Flush coinciding with we_end → level=1 and dato equals the just-written word.
